// File: rtl/pdp8_bus_sched.sv
// Device-side sequencer for the PDP8 nibble-serial bus: decodes beat framing,
// routes each cycle to SRAM or an IOT device, and drives the CPU input nibble.
module pdp8_bus_sched #(
    parameter int                 NDEV      = 4,
    parameter int                 IDW       = 2,
    parameter logic [6*NDEV-1:0]  DEV_CODES = {6'o04, 6'o03, 6'o02, 6'o01}
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [7:0]           bus_out_i,
    output logic [3:0]           bus_in_o,
    output logic [11:0]          mem_addr_o,
    input  logic [11:0]          mem_rdata_i,
    output logic                 mem_re_o,
    output logic                 mem_we_o,
    output logic [11:0]          mem_wdata_o,
    output logic [NDEV-1:0]      dev_sel_o,
    output logic [2:0]           dev_fn_o,
    input  logic [NDEV-1:0]      dev_ready_i,
    input  logic [NDEV-1:0]      dev_skip_i,
    input  logic [NDEV-1:0]      dev_irq_i,
    input  logic [12*NDEV-1:0]   dev_rdata_i,
    output logic                 dev_wr_o,
    output logic [IDW-1:0]       irq_id_o,
    output logic                 frame_err_o
);

    typedef enum logic [2:0] {
        ST_A0   = 3'd0,
        ST_A1   = 3'd1,
        ST_IOD0 = 3'd2,
        ST_D0   = 3'd3,
        ST_D1   = 3'd4,
        ST_D2   = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        lo_q, lo_d;
    logic [11:0]       mem_addr_q, mem_addr_d;
    logic              match_q, match_d;
    logic [IDW-1:0]    dev_idx_q, dev_idx_d;
    logic              io_cyc_q, io_cyc_d;
    logic              wr_q, wr_d;
    logic [11:0]       wdata_q, wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              dev_wr_q, dev_wr_d;
    logic [2:0]        fn_q, fn_d;
    logic [IDW-1:0]    irq_id_q, irq_id_d;
    logic              ferr_q, ferr_d;

    logic              is_a0, is_a1, is_io, is_d0, is_d1, is_d2;
    logic              beat_ok;
    logic              acc_a0, acc_a1, acc_io, acc_d0, acc_d1, acc_d2;
    logic              mem_d0, cur_wr;
    logic              code_hit;
    logic [IDW-1:0]    code_idx;
    logic [IDW-1:0]    irq_pick;
    logic [11:0]       src_rd;
    logic [NDEV-1:0]   sel_oh;
    logic              io_phase;
    logic [3:0]        bus_in_s;
    logic              mem_re_s;

    assign is_a0 = (bus_out_i[7:6] == 2'b10);
    assign is_a1 = (bus_out_i[7:6] == 2'b11);
    assign is_io = (bus_out_i[7:5] == 3'b011) && (bus_out_i[3] == 1'b0);
    assign is_d0 = (bus_out_i[7:5] == 3'b000);
    assign is_d1 = (bus_out_i[7:5] == 3'b001);
    assign is_d2 = (bus_out_i[7:5] == 3'b010);

    // Next-state logic: any unexpected beat falls back to EXP_A0, or straight to EXP_A1 if it is an A0.
    always_comb begin
        state_d = ST_A0;
        beat_ok = 1'b0;
        case (state_q)
            ST_A0:   begin beat_ok = is_a0;         state_d = ST_A1; end
            ST_A1:   begin beat_ok = is_a1;         state_d = ST_IOD0; end
            ST_IOD0: begin beat_ok = is_io | is_d0; state_d = is_io ? ST_D0 : ST_D1; end
            ST_D0:   begin beat_ok = is_d0;         state_d = ST_D1; end
            ST_D1:   begin beat_ok = is_d1;         state_d = ST_D2; end
            ST_D2:   begin beat_ok = is_d2;         state_d = ST_A0; end
            default: begin beat_ok = 1'b0;          state_d = ST_A0; end
        endcase
        if (!beat_ok) begin
            state_d = is_a0 ? ST_A1 : ST_A0;
        end else begin
            state_d = state_d;
        end
    end

    assign acc_a0 = is_a0 && ((state_q == ST_A0) || !beat_ok);
    assign acc_a1 = beat_ok && (state_q == ST_A1);
    assign mem_d0 = (state_q == ST_IOD0) && is_d0;
    assign acc_io = beat_ok && (state_q == ST_IOD0) && is_io;
    assign acc_d0 = beat_ok && (mem_d0 || (state_q == ST_D0));
    assign acc_d1 = beat_ok && (state_q == ST_D1);
    assign acc_d2 = beat_ok && (state_q == ST_D2);
    assign cur_wr = mem_d0 ? bus_out_i[4] : wr_q;

    // Device code lookup on the latched low address; lowest index wins on duplicate codes.
    always_comb begin
        code_hit = 1'b0;
        code_idx = {IDW{1'b0}};
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (lo_q == DEV_CODES[6*i +: 6]) begin
                code_hit = 1'b1;
                code_idx = IDW'(i);
            end else begin
                code_hit = code_hit;
            end
        end
    end

    // Fixed-priority interrupt pick: lowest requesting index.
    always_comb begin
        irq_pick = {IDW{1'b0}};
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (dev_irq_i[i]) begin
                irq_pick = IDW'(i);
            end else begin
                irq_pick = irq_pick;
            end
        end
    end

    // Datapath next-state: address, routing, write capture and strobes.
    always_comb begin
        lo_d       = lo_q;
        mem_addr_d = mem_addr_q;
        match_d    = match_q;
        dev_idx_d  = dev_idx_q;
        io_cyc_d   = io_cyc_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        mem_we_d   = 1'b0;
        dev_wr_d   = 1'b0;
        fn_d       = fn_q;
        irq_id_d   = irq_id_q;
        ferr_d     = !beat_ok;

        if (!beat_ok) begin
            io_cyc_d = 1'b0;
            wr_d     = 1'b0;
        end else begin
            io_cyc_d = io_cyc_d;
        end

        if (acc_a0) begin
            lo_d     = bus_out_i[5:0];
            io_cyc_d = 1'b0;
            wr_d     = 1'b0;
            irq_id_d = (|dev_irq_i) ? irq_pick : irq_id_q;
        end else begin
            lo_d = lo_d;
        end

        if (acc_a1) begin
            mem_addr_d = {bus_out_i[5:0], lo_q};
            match_d    = code_hit;
            dev_idx_d  = code_idx;
        end else begin
            mem_addr_d = mem_addr_d;
        end

        if (acc_io) begin
            io_cyc_d = 1'b1;
            wr_d     = bus_out_i[4];
            fn_d     = bus_out_i[2:0];
        end else begin
            fn_d = fn_d;
        end

        // Write data arrives low nibble first.
        if (acc_d0) begin
            wr_d = cur_wr;
            if (cur_wr) begin
                wdata_d[3:0] = bus_out_i[3:0];
            end else begin
                wdata_d = wdata_d;
            end
        end else if (acc_d1) begin
            if (wr_q) begin
                wdata_d[7:4] = bus_out_i[3:0];
            end else begin
                wdata_d = wdata_d;
            end
        end else if (acc_d2) begin
            if (wr_q) begin
                wdata_d[11:8] = bus_out_i[3:0];
                mem_we_d      = !io_cyc_q;
                dev_wr_d      = io_cyc_q && match_q;
            end else begin
                wdata_d = wdata_d;
            end
        end else begin
            wdata_d = wdata_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_A0;
            lo_q       <= 6'd0;
            mem_addr_q <= 12'd0;
            match_q    <= 1'b0;
            dev_idx_q  <= {IDW{1'b0}};
            io_cyc_q   <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= 12'd0;
            mem_we_q   <= 1'b0;
            dev_wr_q   <= 1'b0;
            fn_q       <= 3'd0;
            irq_id_q   <= {IDW{1'b0}};
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            mem_addr_q <= mem_addr_d;
            match_q    <= match_d;
            dev_idx_q  <= dev_idx_d;
            io_cyc_q   <= io_cyc_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            mem_we_q   <= mem_we_d;
            dev_wr_q   <= dev_wr_d;
            fn_q       <= fn_d;
            irq_id_q   <= irq_id_d;
            ferr_q     <= ferr_d;
        end
    end

    // Read source and one-hot select for the device latched at A1.
    always_comb begin
        sel_oh            = {NDEV{1'b0}};
        sel_oh[dev_idx_q] = match_q;
        if (io_cyc_q) begin
            src_rd = match_q ? dev_rdata_i[12*dev_idx_q +: 12] : 12'd0;
        end else begin
            src_rd = mem_rdata_i;
        end
    end

    // CPU input nibble, memory read enable and device-select window for the current beat.
    always_comb begin
        bus_in_s = 4'd0;
        mem_re_s = 1'b0;
        io_phase = 1'b0;
        if (reset_i) begin
            bus_in_s = 4'd0;
        end else begin
            case (state_q)
                ST_A0: bus_in_s = {3'b000, |dev_irq_i};
                ST_A1: bus_in_s = 4'd0;
                ST_IOD0: begin
                    if (is_io) begin
                        io_phase = 1'b1;
                        bus_in_s = match_q ? {2'b00, dev_skip_i[dev_idx_q], dev_ready_i[dev_idx_q]} : 4'd0;
                    end else if (is_d0 && !bus_out_i[4]) begin
                        mem_re_s = 1'b1;
                        bus_in_s = mem_rdata_i[11:8];
                    end else begin
                        bus_in_s = 4'd0;
                    end
                end
                ST_D0: begin
                    io_phase = io_cyc_q;
                    bus_in_s = wr_q ? 4'd0 : src_rd[11:8];
                end
                ST_D1: begin
                    io_phase = io_cyc_q;
                    mem_re_s = !io_cyc_q && !wr_q;
                    bus_in_s = wr_q ? 4'd0 : src_rd[7:4];
                end
                ST_D2: begin
                    io_phase = io_cyc_q;
                    mem_re_s = !io_cyc_q && !wr_q;
                    bus_in_s = wr_q ? 4'd0 : src_rd[3:0];
                end
                default: bus_in_s = 4'd0;
            endcase
        end
    end

    assign bus_in_o    = bus_in_s;
    assign mem_re_o    = mem_re_s;
    assign dev_sel_o   = io_phase ? sel_oh : {NDEV{1'b0}};
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = wdata_q;
    assign dev_fn_o    = fn_q;
    assign dev_wr_o    = dev_wr_q;
    assign irq_id_o    = irq_id_q;
    assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_pdp8_bus_sched.sv
// Randomized bench for pdp8_bus_sched: a transaction-level model of the bus
// (memory image, device table, latched irq/fn) predicts every observed beat.
module tb_pdp8_bus_sched;

    localparam logic [23:0] CODES = {6'o04, 6'o03, 6'o02, 6'o01};

    logic        clk;
    logic        reset;
    logic [7:0]  bus_out;
    logic [3:0]  bus_in;
    logic [11:0] mem_addr;
    logic [11:0] mem_rdata;
    logic        mem_re;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [3:0]  dev_sel;
    logic [2:0]  dev_fn;
    logic [3:0]  dev_ready;
    logic [3:0]  dev_skip;
    logic [3:0]  dev_irq;
    logic [47:0] dev_rdata;
    logic        dev_wr;
    logic [1:0]  irq_id;
    logic        frame_err;

    logic [11:0] rdat [4];
    logic [11:0] sram [4096];
    logic [11:0] mdl  [4096];
    logic        init_we;
    logic [11:0] init_a;
    logic [11:0] init_d;

    logic [1:0]  e_irq;
    logic [2:0]  e_fn;
    int          n_chk;
    int          n_fail;

    pdp8_bus_sched dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .bus_out_i   (bus_out),
        .bus_in_o    (bus_in),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .mem_re_o    (mem_re),
        .mem_we_o    (mem_we),
        .mem_wdata_o (mem_wdata),
        .dev_sel_o   (dev_sel),
        .dev_fn_o    (dev_fn),
        .dev_ready_i (dev_ready),
        .dev_skip_i  (dev_skip),
        .dev_irq_i   (dev_irq),
        .dev_rdata_i (dev_rdata),
        .dev_wr_o    (dev_wr),
        .irq_id_o    (irq_id),
        .frame_err_o (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dev_rdata = {rdat[3], rdat[2], rdat[1], rdat[0]};
    assign mem_rdata = sram[mem_addr];

    always @(posedge clk) begin
        if (init_we) sram[init_a] <= init_d;
        else if (mem_we) sram[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int find_dev(input logic [5:0] code);
        for (int i = 0; i < 4; i++) begin
            if (CODES[6*i +: 6] == code) return i;
        end
        return -1;
    endfunction

    function automatic logic [1:0] pick_irq(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic beat(input string tag, input logic [7:0] b, input logic cc,
                        input logic [3:0] e_bus, input logic e_re, input logic [3:0] e_sel);
        @(negedge clk);
        bus_out = b;
        #1;
        if (cc) begin
            chk({tag, ".bus_in"}, 32'(bus_in), 32'(e_bus));
            chk({tag, ".mem_re"}, 32'(mem_re), 32'(e_re));
            chk({tag, ".dev_sel"}, 32'(dev_sel), 32'(e_sel));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag, input logic e_we, input logic e_dwr, input logic e_ferr);
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(e_ferr));
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(e_we));
        chk({tag, ".dev_wr"}, 32'(dev_wr), 32'(e_dwr));
        chk({tag, ".irq_id"}, 32'(irq_id), 32'(e_irq));
        chk({tag, ".dev_fn"}, 32'(dev_fn), 32'(e_fn));
    endtask

    // Memory cycle; resync means the A0 arrives while a data beat was expected.
    task automatic do_mem(input logic [11:0] a, input logic w, input logic [11:0] d,
                          input logic [3:0] irq, input logic resync);
        logic [11:0] rd;
        dev_irq = irq;
        beat("memA0", {2'b10, a[5:0]}, !resync, {3'b000, |irq}, 1'b0, 4'd0);
        if (|irq) e_irq = pick_irq(irq);
        chk_regs("memA0", 1'b0, 1'b0, resync);
        beat("memA1", {2'b11, a[11:6]}, 1'b1, 4'd0, 1'b0, 4'd0);
        chk("memA1.addr", 32'(mem_addr), 32'(a));
        chk_regs("memA1", 1'b0, 1'b0, 1'b0);
        rd = mdl[a];
        beat("memD0", {3'b000, w, d[3:0]}, 1'b1, w ? 4'd0 : rd[11:8], !w, 4'd0);
        chk_regs("memD0", 1'b0, 1'b0, 1'b0);
        beat("memD1", {3'b001, w, d[7:4]}, 1'b1, w ? 4'd0 : rd[7:4], !w, 4'd0);
        chk_regs("memD1", 1'b0, 1'b0, 1'b0);
        beat("memD2", {3'b010, w, d[11:8]}, 1'b1, w ? 4'd0 : rd[3:0], !w, 4'd0);
        chk_regs("memD2", w, 1'b0, 1'b0);
        chk("memD2.addr", 32'(mem_addr), 32'(a));
        if (w) begin
            chk("memD2.wdata", 32'(mem_wdata), 32'(d));
            mdl[a] = d;
        end
    endtask

    task automatic do_io(input logic [5:0] code, input logic [5:0] hi, input logic w,
                         input logic [2:0] fn, input logic [11:0] d, input logic [3:0] irq);
        int          idx;
        logic [3:0]  e_sel;
        logic [3:0]  e_io;
        logic [11:0] src;
        idx   = find_dev(code);
        e_sel = 4'd0;
        e_io  = 4'd0;
        src   = 12'd0;
        if (idx >= 0) begin
            e_sel[idx] = 1'b1;
            e_io       = {2'b00, dev_skip[idx], dev_ready[idx]};
            src        = rdat[idx];
        end
        dev_irq = irq;
        beat("ioA0", {2'b10, code}, 1'b1, {3'b000, |irq}, 1'b0, 4'd0);
        if (|irq) e_irq = pick_irq(irq);
        chk_regs("ioA0", 1'b0, 1'b0, 1'b0);
        beat("ioA1", {2'b11, hi}, 1'b1, 4'd0, 1'b0, 4'd0);
        chk("ioA1.addr", 32'(mem_addr), 32'({hi, code}));
        beat("ioIO", {3'b011, w, 1'b0, fn}, 1'b1, e_io, 1'b0, e_sel);
        e_fn = fn;
        chk_regs("ioIO", 1'b0, 1'b0, 1'b0);
        beat("ioD0", {3'b000, w, d[3:0]}, 1'b1, w ? 4'd0 : src[11:8], 1'b0, e_sel);
        beat("ioD1", {3'b001, w, d[7:4]}, 1'b1, w ? 4'd0 : src[7:4], 1'b0, e_sel);
        beat("ioD2", {3'b010, w, d[11:8]}, 1'b1, w ? 4'd0 : src[3:0], 1'b0, e_sel);
        chk_regs("ioD2", 1'b0, w && (idx >= 0), 1'b0);
        if (w && (idx >= 0)) chk("ioD2.wdata", 32'(mem_wdata), 32'(d));
    endtask

    // A0 and A1 of a pool address followed by an out-of-order beat.
    task automatic bad_cycle(input logic [11:0] a, input logic [7:0] bad);
        beat("badA0", {2'b10, a[5:0]}, 1'b1, {3'b000, |dev_irq}, 1'b0, 4'd0);
        if (|dev_irq) e_irq = pick_irq(dev_irq);
        beat("badA1", {2'b11, a[11:6]}, 1'b1, 4'd0, 1'b0, 4'd0);
        beat("badBeat", bad, 1'b0, 4'd0, 1'b0, 4'd0);
        chk_regs("badBeat", 1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic [11:0] pool_addr();
        return {($urandom_range(0, 1) == 1) ? 6'o02 : 6'o41, 1'b0, 5'($urandom)};
    endfunction

    initial begin
        logic [11:0] a;
        logic [5:0]  code;
        logic [3:0]  irq;
        n_chk   = 0;
        n_fail  = 0;
        e_irq   = 2'd0;
        e_fn    = 3'd0;
        reset   = 1'b1;
        bus_out = 8'h00;
        dev_irq = 4'hF;
        dev_ready = 4'd0;
        dev_skip  = 4'd0;
        for (int i = 0; i < 4; i++) rdat[i] = 12'd0;
        init_we = 1'b0;
        init_a  = 12'd0;
        init_d  = 12'd0;

        // Load the memory pool while reset is held.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            init_we = 1'b1;
            init_a  = {(i < 32) ? 6'o02 : 6'o41, 6'(i % 32)};
            init_d  = (init_a == 12'o0200) ? 12'o7402 : 12'($urandom);
            mdl[init_a] = init_d;
        end
        @(negedge clk);
        init_we = 1'b0;
        #1;
        chk("rst.bus_in", 32'(bus_in), 32'd0);
        chk("rst.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst.mem_re", 32'(mem_re), 32'd0);
        chk("rst.dev_sel", 32'(dev_sel), 32'd0);
        chk_regs("rst", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed cases.
        do_mem(12'o0200, 1'b0, 12'd0, 4'd0, 1'b0);
        do_mem(12'o0203, 1'b1, 12'h3A5, 4'd0, 1'b0);
        do_mem(12'o0203, 1'b0, 12'd0, 4'd0, 1'b0);
        rdat[1] = 12'h123; dev_ready = 4'b0010; dev_skip = 4'b0000;
        do_io(CODES[11:6], 6'o00, 1'b0, 3'd5, 12'd0, 4'd0);
        rdat[2] = 12'hABC; dev_ready = 4'b0000; dev_skip = 4'b0100;
        do_io(6'o03, 6'o12, 1'b0, 3'd1, 12'd0, 4'd0);
        do_io(6'o77, 6'o00, 1'b1, 3'd6, 12'h5A5, 4'd0);
        do_io(6'o04, 6'o00, 1'b1, 3'd2, 12'h9C3, 4'd0);
        do_mem(12'o0201, 1'b0, 12'd0, 4'b1100, 1'b0);
        do_mem(12'o0202, 1'b0, 12'd0, 4'b0000, 1'b0);

        // Frame error followed by a clean cycle, then an A0 resync.
        bad_cycle(12'o0204, 8'h20);
        do_mem(12'o0205, 1'b0, 12'd0, 4'd0, 1'b0);
        dev_irq = 4'd0;
        bad_cycle(12'o0206, 8'h40);
        do_mem(12'o0207, 1'b0, 12'd0, 4'b1010, 1'b0);
        beat("rsA0", {2'b10, 6'o10}, 1'b1, 4'd1, 1'b0, 4'd0);
        beat("rsA1", {2'b11, 6'o02}, 1'b1, 4'd0, 1'b0, 4'd0);
        do_mem(12'o0211, 1'b0, 12'd0, 4'b0001, 1'b1);

        // Write aborted by a bad beat in D2 must not reach memory.
        do_mem(12'o4101, 1'b0, 12'd0, 4'd0, 1'b0);
        beat("abA0", {2'b10, 6'o01}, 1'b1, 4'd0, 1'b0, 4'd0);
        beat("abA1", {2'b11, 6'o41}, 1'b1, 4'd0, 1'b0, 4'd0);
        beat("abD0", 8'h1F, 1'b1, 4'd0, 1'b0, 4'd0);
        beat("abD1", 8'h3F, 1'b1, 4'd0, 1'b0, 4'd0);
        beat("abBad", 8'hC0, 1'b0, 4'd0, 1'b0, 4'd0);
        chk_regs("abBad", 1'b0, 1'b0, 1'b1);
        do_mem(12'o4101, 1'b0, 12'd0, 4'd0, 1'b0);

        // Reset during D1 of a write discards it.
        do_mem(12'o0212, 1'b0, 12'd0, 4'b0100, 1'b0);
        dev_irq = 4'd0;
        beat("rwA0", {2'b10, 6'o13}, 1'b1, 4'd0, 1'b0, 4'd0);
        beat("rwA1", {2'b11, 6'o02}, 1'b1, 4'd0, 1'b0, 4'd0);
        beat("rwD0", 8'h17, 1'b1, 4'd0, 1'b0, 4'd0);
        @(negedge clk);
        bus_out = 8'h37;
        reset   = 1'b1;
        dev_irq = 4'hF;
        #1;
        chk("rwRst.bus_in", 32'(bus_in), 32'd0);
        @(posedge clk);
        #1;
        e_irq = 2'd0;
        e_fn  = 3'd0;
        chk("rwRst.mem_addr", 32'(mem_addr), 32'd0);
        chk_regs("rwRst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus_out = 8'h57;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_regs("rwRel", 1'b0, 1'b0, 1'b0);
        do_mem(12'o0213, 1'b0, 12'd0, 4'd0, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            irq = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
            if ((t % 25) == 7) begin
                dev_irq = irq;
                bad_cycle(pool_addr(), {3'b001, 5'($urandom)});
            end else if ($urandom_range(0, 1) == 1) begin
                a = pool_addr();
                do_mem(a, 1'($urandom), 12'($urandom), irq, 1'b0);
            end else begin
                for (int i = 0; i < 4; i++) rdat[i] = 12'($urandom);
                dev_ready = 4'($urandom);
                dev_skip  = 4'($urandom);
                if ($urandom_range(0, 2) != 0) code = CODES[6*$urandom_range(0, 3) +: 6];
                else code = 6'($urandom);
                do_io(code, 6'($urandom), 1'($urandom), 3'($urandom), 12'($urandom), irq);
            end
        end
        beat("tailA0", {2'b10, 6'o00}, 1'b1, {3'b000, |dev_irq}, 1'b0, 4'd0);
        if (|dev_irq) e_irq = pick_irq(dev_irq);
        chk_regs("tailA0", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
